// File: rtl/hazard_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_issue_ctrl
// Purpose  : Small in-order issue controller. Instructions are loaded into a
//            buffer while idle, then issued one per cycle. A bubble is
//            inserted whenever an instruction reads a register written by
//            one of the two most recently issued instructions.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_issue_ctrl #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       start,
   output logic       issue_valid,
   output logic [7:0] issue_instr,
   output logic [2:0] issue_idx,
   output logic       bubble,
   output logic       busy,
   output logic       done,
   output logic [7:0] stall_count
);

   localparam int c_ptr_w = $clog2(DEPTH);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_issue = 2'd1;
   localparam logic [1:0] c_drain = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   localparam logic [1:0] c_op_lw  = 2'b11;
   localparam logic [1:0] c_op_sw  = 2'b10;
   localparam logic [1:0] c_op_add = 2'b01;

   logic [1:0] r_state;
   logic [1:0] w_state_next;

   logic [7:0] r_buf [DEPTH];
   logic [2:0] r_wr_ptr;
   logic [2:0] r_rd_ptr;
   logic [3:0] r_count;
   logic       r_drain_cnt;
   logic [7:0] r_stall_cnt;

   // In-flight tracker: slot 1 issued one cycle ago, slot 2 two cycles ago
   logic       r_s1_valid;
   logic [2:0] r_s1_dst;
   logic       r_s2_valid;
   logic [2:0] r_s2_dst;

   logic [7:0] w_cur;
   logic [1:0] w_op;
   logic [2:0] w_ra;
   logic [2:0] w_rb;
   logic       w_reads_a;
   logic       w_reads_b;
   logic       w_writes;
   logic       w_hit_a;
   logic       w_hit_b;
   logic       w_hazard;
   logic       w_issue_ok;
   logic       w_last;
   logic       w_load;
   logic       w_start_ok;

   assign w_cur = r_buf[r_rd_ptr[c_ptr_w-1:0]];
   assign w_op  = w_cur[7:6];
   assign w_ra  = w_cur[5:3];
   assign w_rb  = w_cur[2:0];

   assign w_reads_a = (w_op == c_op_lw) || (w_op == c_op_add) || (w_op == c_op_sw);
   assign w_reads_b = (w_op == c_op_sw);
   assign w_writes  = (w_op == c_op_lw) || (w_op == c_op_add);

   assign w_hit_a  = (r_s1_valid && (r_s1_dst == w_ra)) || (r_s2_valid && (r_s2_dst == w_ra));
   assign w_hit_b  = (r_s1_valid && (r_s1_dst == w_rb)) || (r_s2_valid && (r_s2_dst == w_rb));
   assign w_hazard = (w_reads_a && w_hit_a) || (w_reads_b && w_hit_b);

   assign w_issue_ok = (r_state == c_issue) && !w_hazard;
   assign w_last     = w_issue_ok && ({1'b0, r_rd_ptr} == (r_count - 4'd1));
   assign w_load     = (r_state == c_idle) && in_valid && (r_count < 4'(DEPTH));
   assign w_start_ok = (r_state == c_idle) && start && (r_count != 4'd0);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= c_idle;
      else        r_state <= w_state_next;
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle:  if (w_start_ok) w_state_next = c_issue;
         c_issue: if (w_last) w_state_next = c_drain;
         c_drain: if (r_drain_cnt) w_state_next = c_done;
         default: w_state_next = c_idle;
      endcase
   end

   // Outputs decoded from registered state, buffer and tracker only
   always_comb begin
      in_ready    = (r_state == c_idle) && (r_count < 4'(DEPTH));
      issue_valid = (r_state == c_issue);
      bubble      = (r_state == c_issue) && w_hazard;
      issue_instr = w_issue_ok ? w_cur : 8'h00;
      issue_idx   = w_issue_ok ? r_rd_ptr : 3'd0;
      busy        = (r_state != c_idle);
      done        = (r_state == c_done);
      stall_count = r_stall_cnt;
   end

   // Instruction buffer storage; contents need no reset
   always_ff @(posedge clk) begin
      if (w_load) r_buf[r_wr_ptr[c_ptr_w-1:0]] <= in_data;
   end

   // Pointers, occupancy, in-flight tracker and stall counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr    <= 3'd0;
         r_rd_ptr    <= 3'd0;
         r_count     <= 4'd0;
         r_drain_cnt <= 1'b0;
         r_stall_cnt <= 8'd0;
         r_s1_valid  <= 1'b0;
         r_s1_dst    <= 3'd0;
         r_s2_valid  <= 1'b0;
         r_s2_dst    <= 3'd0;
      end else begin
         r_drain_cnt <= (r_state == c_drain) ? ~r_drain_cnt : 1'b0;
         if (w_load) begin
            r_wr_ptr <= r_wr_ptr + 3'd1;
            r_count  <= r_count + 4'd1;
         end
         if (w_start_ok) begin
            r_rd_ptr    <= 3'd0;
            r_stall_cnt <= 8'd0;
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
         end
         if ((r_state == c_issue) || (r_state == c_drain)) begin
            r_s2_valid <= r_s1_valid;
            r_s2_dst   <= r_s1_dst;
            r_s1_valid <= w_issue_ok && w_writes;
            r_s1_dst   <= w_rb;
         end
         if (w_issue_ok) r_rd_ptr <= r_rd_ptr + 3'd1;
         if ((r_state == c_issue) && w_hazard && (r_stall_cnt != 8'hFF))
            r_stall_cnt <= r_stall_cnt + 8'd1;
         if (r_state == c_done) begin
            r_count  <= 4'd0;
            r_wr_ptr <= 3'd0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_issue_ctrl
// Purpose  : Randomised and directed bench for hazard_issue_ctrl with a
//            slot-scheduling reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       start;
   logic       issue_valid;
   logic [7:0] issue_instr;
   logic [2:0] issue_idx;
   logic       bubble;
   logic       busy;
   logic       done;
   logic [7:0] stall_count;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0] prog [9];
   logic [7:0] exp_instr [32];
   logic [2:0] exp_idx [32];
   logic       exp_bub [32];
   int         n_slots;
   int         n_bubbles;

   hazard_issue_ctrl #(.DEPTH(8)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .start       (start),
      .issue_valid (issue_valid),
      .issue_instr (issue_instr),
      .issue_idx   (issue_idx),
      .bubble      (bubble),
      .busy        (busy),
      .done        (done),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   // Observed output bundle: {in_ready, issue_valid, bubble, busy, done, idx, instr}
   logic [15:0] w_obs;
   assign w_obs = {in_ready, issue_valid, bubble, busy, done, issue_idx, issue_instr};

   function automatic logic [15:0] pk(input logic ir, input logic iv, input logic bb,
                                      input logic bs, input logic dn,
                                      input logic [2:0] idx, input logic [7:0] ins);
      return {ir, iv, bb, bs, dn, idx, ins};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference schedule: each instruction goes in the earliest slot that is at
   // least three slots after the latest writer of any register it reads.
   task automatic build_slots(input int n);
      int lastw [8];
      int t;
      int need;
      logic [1:0] op;
      logic [2:0] ra;
      logic [2:0] rb;
      for (int r = 0; r < 8; r++) lastw[r] = -10;
      t = 0;
      n_bubbles = 0;
      for (int i = 0; i < n; i++) begin
         op   = prog[i][7:6];
         ra   = prog[i][5:3];
         rb   = prog[i][2:0];
         need = t;
         if (op != 2'b00 && lastw[ra] + 3 > need) need = lastw[ra] + 3;
         if (op == 2'b10 && lastw[rb] + 3 > need) need = lastw[rb] + 3;
         while (t < need) begin
            exp_bub[t] = 1'b1; exp_instr[t] = 8'h00; exp_idx[t] = 3'd0;
            t++;
            n_bubbles++;
         end
         exp_bub[t] = 1'b0; exp_instr[t] = prog[i]; exp_idx[t] = 3'(i);
         if (op == 2'b11 || op == 2'b01) lastw[rb] = t;
         t++;
      end
      n_slots = t;
   endtask

   // Pulse start for one cycle; returns in the first ISSUE cycle
   task automatic do_start();
      in_valid = 1'b0;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   // Checks every cycle of a run from the first ISSUE cycle until back in IDLE,
   // with junk on the load and start inputs while busy.
   task automatic exec(input int n);
      build_slots(n);
      for (int k = 0; k < n_slots; k++) begin
         in_valid = 1'($urandom);
         in_data  = 8'($urandom);
         start    = 1'($urandom);
         check($sformatf("slot%0d", k), {16'd0, w_obs},
               {16'd0, pk(1'b0, 1'b1, exp_bub[k], 1'b1, 1'b0, exp_idx[k], exp_instr[k])});
         step();
      end
      for (int k = 0; k < 2; k++) begin
         check($sformatf("drain%0d", k), {16'd0, w_obs},
               {16'd0, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00)});
         step();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("done_pulse", {16'd0, w_obs}, {16'd0, pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00)});
      check("stall_at_done", {24'd0, stall_count}, n_bubbles);
      step();
      check("idle_after", {16'd0, w_obs}, {16'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00)});
      check("stall_hold", {24'd0, stall_count}, n_bubbles);
   endtask

   // Load n words then run; with comb set, the last load shares its cycle with start
   task automatic run(input int n, input bit comb);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = prog[i];
         start    = comb && (i == n - 1);
         check("in_ready_load", {31'd0, in_ready}, 32'd1);
         step();
      end
      in_valid = 1'b0;
      if (comb) start = 1'b0;
      else      do_start();
      exec(n);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      start    = 1'b0;
      step();
      step();
      check("reset_outs", {16'd0, w_obs}, {16'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00)});
      check("reset_stall", {24'd0, stall_count}, 32'd0);
      rst_n = 1'b1;
      step();
      check("post_reset", {16'd0, w_obs}, {16'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00)});

      // Start with an empty buffer is ignored
      do_start();
      check("start_empty", {31'd0, busy}, 32'd0);

      // Independent instructions
      prog[0] = 8'h4A; prog[1] = 8'h5C; prog[2] = 8'hEE;
      run(3, 1'b0);
      check("s_indep", {24'd0, stall_count}, 32'd0);

      // Distance-1 dependency: two bubbles
      prog[0] = 8'h4A; prog[1] = 8'h53;
      run(2, 1'b0);
      check("s_dist1", {24'd0, stall_count}, 32'd2);

      // Distance-2 dependency: one bubble
      prog[0] = 8'h4A; prog[1] = 8'h00; prog[2] = 8'h53;
      run(3, 1'b0);
      check("s_dist2", {24'd0, stall_count}, 32'd1);

      // lw followed by dependent sw
      prog[0] = 8'hCA; prog[1] = 8'h90;
      run(2, 1'b0);
      check("s_lw_sw", {24'd0, stall_count}, 32'd2);

      // Overfill: nine words offered, eight stored
      for (int i = 0; i < 9; i++) prog[i] = 8'($urandom);
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = prog[i];
         check($sformatf("in_ready_fill%0d", i), {31'd0, in_ready}, (i < 8) ? 32'd1 : 32'd0);
         step();
      end
      do_start();
      exec(8);

      // Reset in the second ISSUE cycle aborts the run
      prog[0] = 8'h01; prog[1] = 8'h42; prog[2] = 8'h83;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = prog[i];
         step();
      end
      do_start();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_idle", {16'd0, w_obs}, {16'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00)});
      check("abort_stall", {24'd0, stall_count}, 32'd0);
      step();
      check("abort_no_done", {30'd0, busy, done}, 32'd0);
      do_start();
      check("abort_start_ignored", {16'd0, w_obs}, {16'd0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00)});
      step();
      check("abort_still_idle", {31'd0, busy}, 32'd0);

      // Randomised programs over a small register set to provoke hazards
      for (int r = 0; r < 40; r++) begin
         int n;
         bit comb;
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++)
            prog[i] = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
         comb = (n >= 2) && ($urandom_range(0, 1) == 1);
         run(n, comb);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
